// File: rtl/mascota_necesidades_pkg.sv
// Shared FSM encoding and width helper for the pet need manager.
package mascota_necesidades_pkg;

  typedef enum logic [1:0] {
    REPOSO      = 2'd0,
    PRESIONANDO = 2'd1,
    SERVIR      = 2'd2
  } estado_t;

  // Bits needed for a counter that must be able to hold the value v itself.
  function automatic int ancho_cnt(input int v);
    return $clog2(v + 1);
  endfunction

endpackage

// File: rtl/mascota_necesidades_canal.sv
// One need channel: button-hold FSM, hold counter and saturating level register.
module mascota_necesidades_canal
  import mascota_necesidades_pkg::*;
#(
  parameter int ANCHO_NIVEL   = 2,
  parameter int SEG_PULSACION = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   boton,
  input  logic                   tick,
  input  logic                   decae,
  input  logic                   reinicio,
  output logic [ANCHO_NIVEL-1:0] nivel,
  output logic                   activo
);

  localparam logic [ANCHO_NIVEL-1:0] NIVEL_MAX = '1;
  localparam int                     HW        = ancho_cnt(SEG_PULSACION);
  localparam logic [HW-1:0]          HOLD_ULT  = HW'(SEG_PULSACION - 1);

  estado_t          estado;
  logic [HW-1:0]    cuenta;
  logic             bloqueo;
  logic             sirve;

  function automatic logic [ANCHO_NIVEL-1:0] sat_inc(input logic [ANCHO_NIVEL-1:0] x);
    return (x == NIVEL_MAX) ? x : x + 1'b1;
  endfunction

  function automatic logic [ANCHO_NIVEL-1:0] sat_dec(input logic [ANCHO_NIVEL-1:0] x);
    return (x == '0) ? x : x - 1'b1;
  endfunction

  // The tick that completes the hold is the serve event; it also beats a coincident decay.
  always_comb begin
    sirve = (estado == PRESIONANDO) && boton && tick && (cuenta == HOLD_ULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado  <= REPOSO;
      cuenta  <= '0;
      nivel   <= NIVEL_MAX;
      activo  <= 1'b0;
      bloqueo <= 1'b0;
    end else if (reinicio) begin
      estado  <= REPOSO;
      cuenta  <= '0;
      nivel   <= NIVEL_MAX;
      activo  <= 1'b0;
      bloqueo <= boton;
    end else begin
      if (!boton) bloqueo <= 1'b0;
      case (estado)
        REPOSO: begin
          if (boton && !bloqueo) begin
            estado <= PRESIONANDO;
            cuenta <= '0;
          end
        end
        PRESIONANDO: begin
          if (!boton) begin
            estado <= REPOSO;
          end else if (sirve) begin
            estado <= SERVIR;
            activo <= 1'b1;
          end else if (tick) begin
            cuenta <= cuenta + 1'b1;
          end
        end
        SERVIR: begin
          if (!boton) begin
            estado <= REPOSO;
            activo <= 1'b0;
          end
        end
        default: estado <= REPOSO;
      endcase
      if (sirve) begin
        nivel <= sat_inc(nivel);
      end else if (decae && (estado != SERVIR)) begin
        nivel <= sat_dec(nivel);
      end
    end
  end

endmodule

// File: rtl/mascota_necesidades.sv
// N-channel need manager: input synchronizers, 1 s prescaler, decay timer, long-press general reset.
module mascota_necesidades
  import mascota_necesidades_pkg::*;
#(
  parameter int N_CANALES       = 2,
  parameter int ANCHO_NIVEL     = 2,
  parameter int CICLOS_SEG      = 50_000_000,
  parameter int SEG_PULSACION   = 5,
  parameter int SEG_DECAIMIENTO = 10,
  parameter int SEG_RESET       = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_CANALES-1:0]             botones,
  input  logic                             boton_reset,
  output logic [N_CANALES*ANCHO_NIVEL-1:0] niveles,
  output logic [N_CANALES-1:0]             activo,
  output logic [N_CANALES-1:0]             alerta,
  output logic                             pulso_reset
);

  localparam int PW = ancho_cnt(CICLOS_SEG);
  localparam int DW = ancho_cnt(SEG_DECAIMIENTO);
  localparam int RW = ancho_cnt(SEG_RESET);

  logic [N_CANALES:0] sync_p0, sync_p1;
  logic [PW-1:0]      cnt_pre;
  logic [DW-1:0]      cnt_dec;
  logic [RW-1:0]      cnt_rst;
  estado_t            est_rst;
  logic               tick, decae, disparo, brst;

  assign brst  = sync_p1[N_CANALES];
  assign tick  = (cnt_pre == PW'(CICLOS_SEG - 1));
  assign decae = tick && (cnt_dec == DW'(SEG_DECAIMIENTO - 1));

  // Stage p0/p1: two-flop synchronizer, bit N_CANALES carries boton_reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= {boton_reset, botones};
      sync_p1 <= sync_p0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_pre <= '0;
      cnt_dec <= '0;
    end else if (disparo) begin
      cnt_pre <= '0;
      cnt_dec <= '0;
    end else begin
      cnt_pre <= tick ? '0 : cnt_pre + 1'b1;
      if (decae)     cnt_dec <= '0;
      else if (tick) cnt_dec <= cnt_dec + 1'b1;
    end
  end

  // SERVIR here means "fired, waiting for release" so a long hold yields a single reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      est_rst     <= REPOSO;
      cnt_rst     <= '0;
      disparo     <= 1'b0;
      pulso_reset <= 1'b0;
    end else begin
      disparo     <= 1'b0;
      pulso_reset <= disparo;
      case (est_rst)
        REPOSO: begin
          if (brst) begin
            est_rst <= PRESIONANDO;
            cnt_rst <= '0;
          end
        end
        PRESIONANDO: begin
          if (!brst) begin
            est_rst <= REPOSO;
          end else if (tick) begin
            cnt_rst <= cnt_rst + 1'b1;
            if (cnt_rst == RW'(SEG_RESET - 1)) begin
              est_rst <= SERVIR;
              disparo <= 1'b1;
            end
          end
        end
        SERVIR: begin
          if (!brst) est_rst <= REPOSO;
        end
        default: est_rst <= REPOSO;
      endcase
    end
  end

  for (genvar g = 0; g < N_CANALES; g++) begin : g_canal
    mascota_necesidades_canal #(
      .ANCHO_NIVEL  (ANCHO_NIVEL),
      .SEG_PULSACION(SEG_PULSACION)
    ) u_canal (
      .clk     (clk),
      .reset   (reset),
      .boton   (sync_p1[g]),
      .tick    (tick),
      .decae   (decae),
      .reinicio(disparo),
      .nivel   (niveles[g*ANCHO_NIVEL +: ANCHO_NIVEL]),
      .activo  (activo[g])
    );
    assign alerta[g] = (niveles[g*ANCHO_NIVEL +: ANCHO_NIVEL] == '0);
  end

endmodule

// File: tb/tb_mascota_necesidades.sv
// Bench for mascota_necesidades: directed timeline, per-cycle model compare and hand-computed checkpoints.
module tb_mascota_necesidades;

  localparam int NC = 3, AN = 2, CS = 4, SP = 3, SD = 5, SR = 2;
  localparam int LMAX = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NC-1:0]     botones = '0;
  logic              boton_reset = 1'b0;
  logic [NC*AN-1:0]  niveles;
  logic [NC-1:0]     activo, alerta;
  logic              pulso_reset;

  always #5 clk = ~clk;

  mascota_necesidades #(
    .N_CANALES(NC), .ANCHO_NIVEL(AN), .CICLOS_SEG(CS),
    .SEG_PULSACION(SP), .SEG_DECAIMIENTO(SD), .SEG_RESET(SR)
  ) dut (
    .clk(clk), .reset(reset), .botones(botones), .boton_reset(boton_reset),
    .niveles(niveles), .activo(activo), .alerta(alerta), .pulso_reset(pulso_reset)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  // Reference: per-channel "seconds held" bookkeeping; st 0 idle, 1 holding, 2 being served.
  typedef struct {
    int lvl[NC];
    int st[NC];
    int held[NC];
    bit blk[NC];
    int sub_sec;
    int secs_since_decay;
    int rst_st;
    int rst_held;
    bit fire;
    bit pulse;
    bit [NC:0] s0;
    bit [NC:0] s1;
  } model_t;

  function automatic model_t model_reset();
    model_t n;
    for (int i = 0; i < NC; i++) begin
      n.lvl[i] = LMAX; n.st[i] = 0; n.held[i] = 0; n.blk[i] = 1'b0;
    end
    n.sub_sec = 0; n.secs_since_decay = 0; n.rst_st = 0; n.rst_held = 0;
    n.fire = 1'b0; n.pulse = 1'b0; n.s0 = '0; n.s1 = '0;
    return n;
  endfunction

  function automatic model_t model_step(model_t o, bit [NC:0] pins);
    model_t n = o;
    bit [NC:0] b = o.s1;
    bit second = (o.sub_sec == CS - 1);
    bit decay = second && (o.secs_since_decay == SD - 1);
    n.fire = 1'b0;
    n.pulse = o.fire;
    case (o.rst_st)
      0: if (b[NC]) begin n.rst_st = 1; n.rst_held = 0; end
      1: begin
        if (!b[NC]) n.rst_st = 0;
        else if (second) begin
          n.rst_held = o.rst_held + 1;
          if (n.rst_held == SR) begin n.rst_st = 2; n.fire = 1'b1; end
        end
      end
      default: if (!b[NC]) n.rst_st = 0;
    endcase
    if (o.fire) begin
      for (int i = 0; i < NC; i++) begin
        n.lvl[i] = LMAX; n.st[i] = 0; n.held[i] = 0; n.blk[i] = b[i];
      end
      n.sub_sec = 0;
      n.secs_since_decay = 0;
    end else begin
      n.sub_sec = second ? 0 : o.sub_sec + 1;
      if (second) n.secs_since_decay = decay ? 0 : o.secs_since_decay + 1;
      for (int i = 0; i < NC; i++) begin
        bit served = 1'b0;
        if (!b[i]) n.blk[i] = 1'b0;
        case (o.st[i])
          0: if (b[i] && !o.blk[i]) begin n.st[i] = 1; n.held[i] = 0; end
          1: begin
            if (!b[i]) n.st[i] = 0;
            else if (second) begin
              n.held[i] = o.held[i] + 1;
              if (n.held[i] == SP) begin n.st[i] = 2; served = 1'b1; end
            end
          end
          default: if (!b[i]) n.st[i] = 0;
        endcase
        if (served) n.lvl[i] = (o.lvl[i] < LMAX) ? o.lvl[i] + 1 : LMAX;
        else if (decay && o.st[i] != 2 && o.lvl[i] > 0) n.lvl[i] = o.lvl[i] - 1;
      end
    end
    n.s1 = o.s0;
    n.s0 = pins;
    return n;
  endfunction

  model_t m = model_reset();

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= model_reset();
    else        m <= model_step(m, {boton_reset, botones});
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [NC*AN-1:0] exp_niveles(model_t x);
    logic [NC*AN-1:0] v = '0;
    for (int i = 0; i < NC; i++) v[i*AN +: AN] = AN'(x.lvl[i]);
    return v;
  endfunction

  function automatic logic [NC-1:0] exp_activo(model_t x);
    logic [NC-1:0] v = '0;
    for (int i = 0; i < NC; i++) v[i] = (x.st[i] == 2);
    return v;
  endfunction

  function automatic logic [NC-1:0] exp_alerta(model_t x);
    logic [NC-1:0] v = '0;
    for (int i = 0; i < NC; i++) v[i] = (x.lvl[i] == 0);
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_niveles", 32'(niveles), 32'(exp_niveles(m)));
      chk("model_activo", 32'(activo), 32'(exp_activo(m)));
      chk("model_alerta", 32'(alerta), 32'(exp_alerta(m)));
      chk("model_pulso_reset", 32'(pulso_reset), 32'(m.pulse));
    end
  end

  task automatic at_cycle(input int k);
    int guard = 0;
    while (cyc < k && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < k) begin
      n_cmp++;
      n_err++;
      $display("FAIL at_cycle_timeout: reached %0d, wanted %0d", cyc, k);
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    #1 chk_en = 1'b1;
    chk("reset_niveles", 32'(niveles), 32'h3F);
    chk("reset_activo", 32'(activo), 32'h0);
    chk("reset_alerta", 32'(alerta), 32'h0);
    chk("reset_pulso", 32'(pulso_reset), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    at_cycle(18);  chk("idle_before_decay", 32'(niveles), 32'h3F);
    at_cycle(21);  chk("first_decay", 32'(niveles), 32'b101010);
    at_cycle(41);  botones[1] = 1'b1;
    at_cycle(57);  chk("ch1_served_lvl", 32'(niveles[3:2]), 32'd2);
                   chk("ch0_lvl_1", 32'(niveles[1:0]), 32'd1);
                   chk("ch1_activo", 32'(activo), 32'b010);
    at_cycle(61);  chk("alerta_idle_chans", 32'(alerta), 32'b101);
                   chk("ch1_no_decay_serving", 32'(niveles[3:2]), 32'd2);
    at_cycle(97);  chk("ch1_long_hold_lvl", 32'(niveles[3:2]), 32'd2);
                   chk("ch1_long_hold_activo", 32'(activo), 32'b010);
                   botones[1] = 1'b0;
    at_cycle(101); chk("ch1_after_release", 32'(niveles[3:2]), 32'd2);
                   chk("activo_after_release", 32'(activo), 32'b000);
                   botones[0] = 1'b1;
    at_cycle(111); botones[0] = 1'b0;
    at_cycle(116); chk("ch0_short_hold_lvl", 32'(niveles[1:0]), 32'd0);
                   chk("ch0_short_hold_activo", 32'(activo), 32'b000);
    at_cycle(127); botones[1] = 1'b1;
    at_cycle(141); chk("inc_beats_decay", 32'(niveles[3:2]), 32'd2);
                   chk("inc_beats_decay_activo", 32'(activo), 32'b010);
                   botones[1] = 1'b0;
    at_cycle(161); boton_reset = 1'b1; botones[2] = 1'b1;
    at_cycle(172); chk("pulso_not_yet", 32'(pulso_reset), 32'd0);
    at_cycle(173); chk("pulso_fires", 32'(pulso_reset), 32'd1);
                   chk("greset_niveles", 32'(niveles), 32'h3F);
                   chk("greset_activo", 32'(activo), 32'b000);
    at_cycle(174); chk("pulso_one_cycle", 32'(pulso_reset), 32'd0);
                   botones[0] = 1'b1;
    at_cycle(190); chk("sat_serve_lvl", 32'(niveles[1:0]), 32'd3);
                   chk("blocked_ch2_activo", 32'(activo), 32'b001);
                   botones[0] = 1'b0;
    at_cycle(196); chk("post_greset_decay", 32'(niveles), 32'b101011);
    at_cycle(200); boton_reset = 1'b0; botones[2] = 1'b0;
    at_cycle(201); botones[1] = 1'b1;
    at_cycle(209); botones[0] = 1'b1;
    at_cycle(219); chk("pre_async_activo", 32'(activo), 32'b010);
    #1 reset = 1'b0;
    #1 chk("async_niveles", 32'(niveles), 32'h3F);
       chk("async_activo", 32'(activo), 32'b000);
       chk("async_alerta", 32'(alerta), 32'b000);
       chk("async_pulso", 32'(pulso_reset), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    at_cycle(11);  chk("rehold_not_served", 32'(activo), 32'b000);
    at_cycle(13);  chk("rehold_served", 32'(activo), 32'b011);
                   chk("rehold_niveles", 32'(niveles), 32'h3F);
                   botones = '0;
    at_cycle(30);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
